// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer.
//   chan_state_t : per-channel debounce FSM state encoding
//   cnt_width()  : ceil(log2(n)) counter width, never less than 1 bit
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } chan_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while (w < 32 && (32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/btn_deb_chan.sv
// One debounce channel: 2-flop synchronizer, debounce FSM, debounce and
// auto-repeat counters, registered level/press/release outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw bouncing button input (1 = pressed)
//   level      : debounced level (1 while held or confirming a release)
//   press      : one-cycle pulse per accepted press / auto-repeat
//   rel        : one-cycle pulse per accepted release
module btn_deb_chan
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 262144,
  parameter int unsigned RPT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned DW     = cnt_width(DEB_CYCLES);
  localparam int unsigned RW     = cnt_width(RPT_CYCLES + 1);
  localparam bit          RPT_EN = (RPT_CYCLES != 0);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(RPT_EN ? RPT_CYCLES - 1 : 0);

  logic [1:0]    sync;
  logic          s;
  chan_state_t   state, state_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [RW-1:0] rpt_cnt, rpt_n;
  logic          press_evt, rel_evt;
  logic          press_p, rel_p;

  assign s = sync[1];

  always_comb begin
    state_n   = state;
    deb_n     = deb_cnt;
    rpt_n     = rpt_cnt;
    press_evt = 1'b0;
    rel_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_n = PRESS_CHK;
          deb_n   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_n = IDLE;
          deb_n   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_n   = HELD;
          rpt_n     = '0;
          press_evt = 1'b1;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_n = REL_CHK;
          deb_n   = '0;
        end else if (RPT_EN) begin
          if (rpt_cnt == RPT_LAST) begin
            rpt_n     = '0;
            press_evt = 1'b1;
          end else begin
            rpt_n = rpt_cnt + 1'b1;
          end
        end
      end
      REL_CHK: begin
        // Bounce back to HELD keeps the repeat phase (counter frozen here).
        if (s) begin
          state_n = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_n = IDLE;
          rel_evt = 1'b1;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Events are staged once so pulses line up with level, which is
  // registered from the already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      state   <= IDLE;
      deb_cnt <= '0;
      rpt_cnt <= '0;
      press_p <= 1'b0;
      rel_p   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      level   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      state   <= state_n;
      deb_cnt <= deb_n;
      rpt_cnt <= rpt_n;
      press_p <= press_evt;
      rel_p   <= rel_evt;
      press   <= press_p;
      rel     <= rel_p;
      level   <= (state == HELD) || (state == REL_CHK);
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer with optional auto-repeat.
//   Bus2IP_Clk    : clock
//   Bus2IP_Resetn : asynchronous active-low reset
//   btn_raw       : raw bouncing buttons, 1 = pressed
//   btn_level     : debounced levels (registered)
//   btn_press     : one-cycle pulse per accepted press / auto-repeat
//   btn_release   : one-cycle pulse per accepted release
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN    = 3,
  parameter int unsigned DEB_CYCLES = 262144,
  parameter int unsigned RPT_CYCLES = 0
) (
  input  logic               Bus2IP_Clk,
  input  logic               Bus2IP_Resetn,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_deb_chan #(
      .DEB_CYCLES(DEB_CYCLES),
      .RPT_CYCLES(RPT_CYCLES)
    ) u_chan (
      .clk  (Bus2IP_Clk),
      .rst_n(Bus2IP_Resetn),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed vector table, hand-written
// corner sequences and a randomized run, all against a reference model that
// accepts a level after DEB_CYCLES+1 consecutive differing synchronized samples.
module tb_btn_debounce;

  localparam int DEB = 4;
  localparam int RPT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_raw = '0;
  logic [2:0] level0, press0, rel0;
  logic [2:0] level1, press1, rel1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_debounce #(.NUM_BTN(3), .DEB_CYCLES(DEB), .RPT_CYCLES(0)) u_dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .btn_raw(btn_raw),
    .btn_level(level0), .btn_press(press0), .btn_release(rel0));

  btn_debounce #(.NUM_BTN(3), .DEB_CYCLES(DEB), .RPT_CYCLES(RPT)) u_rpt (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .btn_raw(btn_raw),
    .btn_level(level1), .btn_press(press1), .btn_release(rel1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         rpt_period[2] = '{0, RPT};
  bit         acc[2][3];
  int         run[2][3];
  int         rcnt[2][3];
  bit         pend_p[2][3], pend_r[2][3];
  logic [2:0] e_level[2], e_press[2], e_rel[2];
  logic [2:0] smp_1, smp_2;  // raw sampled one / two edges ago

  task automatic model_clear();
    smp_1 = '0;
    smp_2 = '0;
    for (int i = 0; i < 2; i++) begin
      e_level[i] = '0; e_press[i] = '0; e_rel[i] = '0;
      for (int c = 0; c < 3; c++) begin
        acc[i][c] = 0; run[i][c] = 0; rcnt[i][c] = 0;
        pend_p[i][c] = 0; pend_r[i][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic [2:0] s;
    s = smp_2;
    smp_2 = smp_1;
    smp_1 = btn_raw;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) begin
        e_level[i][c] = acc[i][c];
        e_press[i][c] = pend_p[i][c];
        e_rel[i][c]   = pend_r[i][c];
        pend_p[i][c] = 0;
        pend_r[i][c] = 0;
        if (s[c] != acc[i][c]) begin
          run[i][c]++;
          if (run[i][c] == DEB + 1) begin
            acc[i][c]  = s[c];
            run[i][c]  = 0;
            rcnt[i][c] = 0;
            if (s[c]) pend_p[i][c] = 1; else pend_r[i][c] = 1;
          end
        end else begin
          // steadily held (no pending release check): count toward repeat
          if (acc[i][c] && run[i][c] == 0 && rpt_period[i] > 0) begin
            rcnt[i][c]++;
            if (rcnt[i][c] == rpt_period[i]) begin
              rcnt[i][c] = 0;
              pend_p[i][c] = 1;
            end
          end
          run[i][c] = 0;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("model_level0", {29'd0, level0}, {29'd0, e_level[0]});
      chk("model_press0", {29'd0, press0}, {29'd0, e_press[0]});
      chk("model_rel0",   {29'd0, rel0},   {29'd0, e_rel[0]});
      chk("model_level1", {29'd0, level1}, {29'd0, e_level[1]});
      chk("model_press1", {29'd0, press1}, {29'd0, e_press[1]});
      chk("model_rel1",   {29'd0, rel1},   {29'd0, e_rel[1]});
      chk("press_rel_excl", {29'd0, (press0 & rel0) | (press1 & rel1)}, 32'd0);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0] raw;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] rel;
  } vec_t;

  vec_t tab[30];

  task automatic idle(input int n);
    btn_raw = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int npress;
    int hold[3];
    logic [2:0] rv;

    // btn0 pressed at row 0, released at row 20; outputs observed after edge k
    for (int k = 0; k < 30; k++) begin
      tab[k].raw   = (k < 20) ? 3'b001 : 3'b000;
      tab[k].level = (k >= 7 && k < 27) ? 3'b001 : 3'b000;
      tab[k].press = (k == 7) ? 3'b001 : 3'b000;
      tab[k].rel   = (k == 27) ? 3'b001 : 3'b000;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", {29'd0, level0}, 32'd0);
    chk("rst_press", {29'd0, press0}, 32'd0);
    chk("rst_rel",   {29'd0, rel0},   32'd0);
    chk("rst_level_rpt", {29'd0, level1}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    for (int k = 0; k < 30; k++) begin
      btn_raw = tab[k].raw;
      @(negedge clk);
      chk("tab_level", {29'd0, level0}, {29'd0, tab[k].level});
      chk("tab_press", {29'd0, press0}, {29'd0, tab[k].press});
      chk("tab_rel",   {29'd0, rel0},   {29'd0, tab[k].rel});
    end
    idle(5);

    // short bounces on btn1 never qualify
    for (int k = 0; k < 18; k++) begin
      btn_raw = (k < 8 && (k % 4) < 2) ? 3'b010 : 3'b000;
      @(negedge clk);
      chk("bounce_level1", {31'd0, level0[1]}, 32'd0);
      chk("bounce_pulse1", {30'd0, press0[1], rel0[1]}, 32'd0);
    end

    // held btn0 with a 2-cycle dropout, then a genuine release
    btn_raw = 3'b001;
    repeat (12) @(negedge clk);
    chk("hold_level0", {31'd0, level0[0]}, 32'd1);
    for (int k = 0; k < 12; k++) begin
      btn_raw = (k < 2) ? 3'b000 : 3'b001;
      @(negedge clk);
      chk("dropout_level0", {31'd0, level0[0]}, 32'd1);
      chk("dropout_rel0",   {31'd0, rel0[0]},   32'd0);
    end
    btn_raw = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("final_rel0",   {31'd0, rel0[0]},   (k == 7) ? 32'd1 : 32'd0);
      chk("final_level0", {31'd0, level0[0]}, (k < 7) ? 32'd1 : 32'd0);
    end
    idle(5);

    // auto-repeat on btn2 of the RPT instance
    npress = 0;
    for (int k = 0; k < 50; k++) begin
      btn_raw = (k < 40) ? 3'b100 : 3'b000;
      @(negedge clk);
      if (press1[2]) npress++;
      chk("rpt_press2", {31'd0, press1[2]},
          (k == 7 || k == 17 || k == 27 || k == 37) ? 32'd1 : 32'd0);
    end
    chk("rpt_count", npress, 32'd4);
    idle(5);

    // simultaneous press, then reset while held
    btn_raw = 3'b111;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("all_press", {29'd0, press0}, (k == 7) ? 32'd7 : 32'd0);
    end
    chk("all_level", {29'd0, level0}, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("rst_now_level", {29'd0, level0}, 32'd0);
    chk("rst_now_level_rpt", {29'd0, level1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rerun_press", {29'd0, press0}, (k == 7) ? 32'd7 : 32'd0);
      chk("rerun_rel",   {29'd0, rel0},   32'd0);
    end
    idle(12);

    // randomized bouncing on all channels, rare resets
    rv = '0;
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          rv[c] = ~rv[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
        end else begin
          hold[c]--;
        end
      end
      btn_raw = rv;
      rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
